// File: rtl/neural_result_sequencer.sv
// neural_result_sequencer: serial class-score argmax with seven-segment result.
// Ports: clk, rst (sync, active-high); score_valid/score_in/score_ready stream
//   input; frame_abort drops a partial frame; result_valid pulses per result;
//   digit_out/seven_seg hold the last result; busy marks a partial frame.
module neural_result_sequencer #(
    parameter int                 NUM_CLASSES = 10,
    parameter int                 SCORE_W     = 16,
    parameter logic [SCORE_W-1:0] MIN_SCORE   = 16'h0080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score_in,
    output logic               score_ready,
    input  logic               frame_abort,
    output logic               result_valid,
    output logic [3:0]         digit_out,
    output logic [7:0]         seven_seg,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PUBLISH
    } state_t;

    state_t             r_state;
    logic [3:0]         r_count;
    logic [SCORE_W-1:0] r_max_val;
    logic [3:0]         r_max_idx;
    logic               r_result_valid;
    logic [3:0]         r_digit;
    logic [7:0]         r_seg;

    logic w_accept;
    logic w_last;
    logic w_higher;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        s = 8'h40;
        unique case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h40;
        endcase
        return s;
    endfunction

    // Ready is a pure function of state; abort suppresses the accept.
    assign score_ready = (r_state != S_PUBLISH);
    assign w_accept    = score_valid && score_ready && !frame_abort;
    assign w_last      = (r_count == 4'(NUM_CLASSES - 1));
    assign w_higher    = (score_in > r_max_val);

    assign result_valid = r_result_valid;
    assign digit_out    = r_digit;
    assign seven_seg    = r_seg;
    assign busy         = (r_state == S_COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= 4'd0;
            r_max_val      <= '0;
            r_max_idx      <= 4'd0;
            r_result_valid <= 1'b0;
            r_digit        <= 4'hF;
            r_seg          <= 8'h00;
        end else begin
            r_result_valid <= 1'b0;
            unique case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (frame_abort) begin
                        r_state   <= S_IDLE;
                        r_count   <= 4'd0;
                        r_max_val <= '0;
                        r_max_idx <= 4'd0;
                    end else if (w_accept) begin
                        // Index 0 always loads; later ones need a strict win.
                        if (r_count == 4'd0) begin
                            r_max_val <= score_in;
                            r_max_idx <= 4'd0;
                        end else if (w_higher) begin
                            r_max_val <= score_in;
                            r_max_idx <= r_count;
                        end
                        if (w_last) begin
                            r_state <= S_PUBLISH;
                            r_count <= 4'd0;
                        end else begin
                            r_state <= S_COLLECT;
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                S_PUBLISH: begin
                    r_result_valid <= 1'b1;
                    if (r_max_val >= MIN_SCORE) begin
                        r_digit <= r_max_idx;
                        r_seg   <= seg_of(r_max_idx);
                    end else begin
                        r_digit <= 4'hF;
                        r_seg   <= 8'h40;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neural_result_sequencer.sv
// tb_neural_result_sequencer: directed plus randomized frames against an
// argmax reference model; checks handshake, timing, display and busy.
module tb_neural_result_sequencer;

    logic        clk;
    logic        rst;
    logic        score_valid;
    logic [15:0] score_in;
    logic        score_ready;
    logic        frame_abort;
    logic        result_valid;
    logic [3:0]  digit_out;
    logic [7:0]  seven_seg;
    logic        busy;

    int n_chk;
    int n_pass;

    logic [3:0]  exp_digit;
    logic [7:0]  exp_seg;
    logic [15:0] fr [10];
    logic [7:0]  seg_tab [10];

    neural_result_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .score_valid  (score_valid),
        .score_in     (score_in),
        .score_ready  (score_ready),
        .frame_abort  (frame_abort),
        .result_valid (result_valid),
        .digit_out    (digit_out),
        .seven_seg    (seven_seg),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the largest value wins.
    task automatic model(input logic [15:0] sc [10]);
        int best;
        best = 0;
        for (int i = 1; i < 10; i++)
            if (sc[i] > sc[best]) best = i;
        if (sc[best] < 16'h0080) begin
            exp_digit = 4'hF;
            exp_seg   = 8'h40;
        end else begin
            exp_digit = 4'(best);
            exp_seg   = seg_tab[best];
        end
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_digit"}, 32'(digit_out), 32'(exp_digit));
        chk({tag, "_seg"}, 32'(seven_seg), 32'(exp_seg));
    endtask

    task automatic send_frame(input logic [15:0] sc [10],
                              input int gap_idx, input int gap_len);
        for (int i = 0; i < 10; i++) begin
            if (i == gap_idx) begin
                score_valid = 1'b0;
                score_in    = 16'(~sc[i]);
                for (int g = 0; g < gap_len; g++) begin
                    step();
                    chk("gap_busy", 32'(busy), 32'(i > 0));
                    chk("gap_rv", 32'(result_valid), 0);
                end
            end
            score_valid = 1'b1;
            score_in    = sc[i];
            chk("ready", 32'(score_ready), 1);
            chk("busy", 32'(busy), 32'(i > 0));
            step();
        end
        score_valid = 1'b0;
        chk_hold("hold");
        model(sc);
        chk("pub_ready", 32'(score_ready), 0);
        chk("pub_rv_early", 32'(result_valid), 0);
        chk("pub_busy", 32'(busy), 0);
        step();
        chk("pub_rv", 32'(result_valid), 1);
        chk("pub_ready_back", 32'(score_ready), 1);
        chk_hold("pub");
        step();
        chk("rv_pulse", 32'(result_valid), 0);
        chk_hold("post");
    endtask

    task automatic send_partial(input int k);
        for (int i = 0; i < k; i++) begin
            score_valid = 1'b1;
            score_in    = 16'($urandom);
            step();
            chk("part_rv", 32'(result_valid), 0);
        end
    endtask

    task automatic do_abort();
        score_valid = 1'b1;
        score_in    = 16'hFFFF;
        frame_abort = 1'b1;
        step();
        frame_abort = 1'b0;
        score_valid = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rv", 32'(result_valid), 0);
        chk_hold("abort");
        step();
        chk("abort_rv2", 32'(result_valid), 0);
        chk("abort_ready", 32'(score_ready), 1);
        chk_hold("abort2");
    endtask

    initial begin
        int mode;
        int gi;
        n_chk = 0;
        n_pass = 0;
        seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        rst = 1'b1;
        score_valid = 1'b0;
        score_in = 16'h0;
        frame_abort = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_digit = 4'hF;
        exp_seg = 8'h00;
        chk_hold("reset");
        chk("reset_rv", 32'(result_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(score_ready), 1);

        fr = '{16'h07F2, 16'h01BB, 16'h00BF, 16'h01D7, 16'h0065,
               16'h0208, 16'h001A, 16'h0037, 16'h001F, 16'h0017};
        send_frame(fr, -1, 0);
        chk("plan1_digit", 32'(digit_out), 0);

        fr = '{16'h00C5, 16'h002F, 16'h0104, 16'h0018, 16'h0F26,
               16'h0012, 16'h0026, 16'h005C, 16'h002A, 16'h00E9};
        send_frame(fr, 3, 3);
        chk("plan2_seg", 32'(seven_seg), 32'h66);

        for (int i = 0; i < 10; i++) fr[i] = 16'h0010;
        fr[3] = 16'h0500;
        fr[7] = 16'h0500;
        send_frame(fr, -1, 0);
        chk("tie_digit", 32'(digit_out), 3);

        for (int i = 0; i < 10; i++) fr[i] = 16'h0040;
        send_frame(fr, -1, 0);
        chk("low_seg", 32'(seven_seg), 32'h40);
        fr[9] = 16'h0300;
        send_frame(fr, -1, 0);
        chk("nine_seg", 32'(seven_seg), 32'h6F);

        for (int i = 0; i < 10; i++) fr[i] = 16'h0010;
        fr[6] = 16'h007F;
        send_frame(fr, -1, 0);
        fr[2] = 16'h0080;
        send_frame(fr, -1, 0);
        chk("min_edge", 32'(digit_out), 2);

        send_partial(5);
        do_abort();
        fr = '{16'h0100, 16'h0010, 16'h0010, 16'h0010, 16'h0010,
               16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        send_frame(fr, -1, 0);
        chk("after_abort", 32'(digit_out), 0);

        send_partial(9);
        do_abort();

        send_partial(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        score_valid = 1'b0;
        exp_digit = 4'hF;
        exp_seg = 8'h00;
        chk_hold("midrst");
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(score_ready), 1);
        fr = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010,
               16'h0010, 16'h0010, 16'h0900, 16'h0010, 16'h0010};
        send_frame(fr, -1, 0);
        chk("after_rst", 32'(digit_out), 7);

        for (int f = 0; f < 40; f++) begin
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 10; i++) begin
                unique case (mode)
                    0: fr[i] = 16'($urandom);
                    1: fr[i] = 16'($urandom_range(0, 16'h009F));
                    2: fr[i] = 16'($urandom_range(0, 3) << 8);
                    default: fr[i] = 16'($urandom_range(16'h0078, 16'h0088));
                endcase
            end
            if ($urandom_range(0, 5) == 0) begin
                send_partial($urandom_range(0, 9));
                do_abort();
            end
            gi = $urandom_range(0, 14);
            send_frame(fr, gi, $urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/neural_result_sequencer.md
# neural_result_sequencer

Sequential scoring controller between the neural network output stage and the board's seven-segment display. It accepts one frame of class scores serially over a valid/ready handshake and tracks the running maximum as each score arrives. At frame end it registers the winning class digit and its seven-segment pattern, and holds the display until the next frame completes. It replaces a wide parallel score bus with a 16-bit stream and adds frame abort and low-confidence blanking.

## Interface
- NUM_CLASSES, 10: scores per frame; legal range 2..10.
- SCORE_W, 16: score width; unsigned fixed-point.
- MIN_SCORE, 16'h0080: a winning score below this displays a dash.

- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- score_valid  in  1  score_in is valid this cycle.
- score_in  in  SCORE_W  score for the current class index; classes arrive in order 0..NUM_CLASSES-1.
- score_ready  out  1  block can accept a score.
- frame_abort  in  1  discard the partial frame.
- result_valid  out  1  one-cycle pulse when a new result is registered.
- digit_out  out  4  winning class index, or 4'hF for low confidence.
- seven_seg  out  8  active-high {dp,g,f,e,d,c,b,a}.
- busy  out  1  high while a frame is partially received.

## Operation
- States:
  - IDLE: count=0.
  - COLLECT: 0 < count < NUM_CLASSES.
  - PUBLISH: one cycle.
- Accept rule: a score is accepted on a rising edge when score_valid && score_ready. score_ready=1 in IDLE and COLLECT, 0 in PUBLISH.
- Running maximum:
  - The first accepted score (index 0) loads max_val=score_in and max_idx=0.
  - Each later score updates both only if score_in > max_val, using an unsigned strict compare. Ties keep the lower index.
- Counter: count increments on each accept.
  - IDLE goes to COLLECT on the first accept.
  - The accept with count==NUM_CLASSES-1 moves to PUBLISH. The compare includes this final score.
- PUBLISH:
  - If max_val >= MIN_SCORE: digit_out=max_idx and seven_seg=the digit pattern.
  - Otherwise: digit_out=4'hF and seven_seg=8'h40 (dash).
  - result_valid=1, then the state goes to IDLE.
- Digit patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. dp is always 0.
- digit_out and seven_seg are registered. They change only in PUBLISH or on reset, and otherwise hold the last result.
- frame_abort, sampled high in COLLECT or IDLE:
  - Returns to IDLE with count=0 and clears max.
  - No accept occurs that cycle, even with score_valid high.
  - Outputs are unchanged and result_valid stays 0.
- frame_abort in PUBLISH is ignored; the publish completes.
- busy = (state==COLLECT).
- Gaps in score_valid stall the frame indefinitely. There is no timeout.

## Timing
- Reset values (rst high at an edge, any state): state=IDLE, count=0, max_val=0, max_idx=0, result_valid=0, digit_out=4'hF, seven_seg=8'h00 (blank), busy=0, score_ready=1 on the cycle after.
- Reset has priority over abort and accept.
- Latency: result_valid rises on the first edge after the edge that accepted the last score, then lasts exactly one cycle.
- Throughput: back-to-back frames give NUM_CLASSES accepts followed by one ready-low bubble. That is NUM_CLASSES+1 cycles per frame.
- score_ready depends only on state, with no combinational path from score_valid.
- Simultaneous events:
  - frame_abort with the last score: abort wins and no publish occurs.
  - rst mid-COLLECT: the partial frame is lost and the display blanks.

## Test plan
- Reset then stream frame 07F2,01BB,00BF,01D7,0065,0208,001A,0037,001F,0017 with valid held high:
  - ready stays high for 10 cycles.
  - result_valid pulses 1 cycle after the 10th accept.
  - digit_out=0, seven_seg=3F.
  - ready is low for exactly one cycle.
- Frame 00C5,002F,0104,0018,0F26,0012,0026,005C,002A,00E9 with valid deasserted for 3 cycles after index 2:
  - digit_out=4, seven_seg=66.
  - busy is high throughout the gap.
- Tie: indices 3 and 7 both 0500, others 0010 → digit_out=3, seven_seg=4F.
- Low confidence: all scores 0040 → digit_out=F, seven_seg=40. A following valid frame with max at index 9 → digit_out=9, seven_seg=6F.
- Abort after 5 accepts: no result_valid and the previous display is held. A fresh full frame then publishes correctly (count restarted at index 0).
- rst asserted after 6 accepts: next cycle seven_seg=00, digit_out=F, busy=0. A subsequent full frame publishes normally.
